// File: rtl/wb_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths and the write-back request record for the
//            register-file write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN         = 64;
    localparam int REG_ADDR_W   = 5;
    localparam int STARVE_LIMIT = 3;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // x0 is hardwired to zero, so writes to it are dropped.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
        return (rd == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_writeback_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous FIFO of write-back requests with occupancy count.
//            DEPTH must be a power of two so the pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  wb_req_t                    i_din,
    input  logic                       i_pop,
    output wb_req_t                    o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    wb_req_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_arbiter
// Purpose  : Arbitrates ALU and load results onto the single register-file
//            write port; ALU results wait in a small FIFO. Optional
//            write-port bypass compare enabled by WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_writeback_arbiter #(
    parameter int XLEN         = wb_pkg::XLEN,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]               mem_data,
    output logic                          rf_we,
    output logic [wb_pkg::REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]               rf_wdata,
    input  logic [wb_pkg::REG_ADDR_W-1:0] rs1,
    input  logic [wb_pkg::REG_ADDR_W-1:0] rs2,
    output logic                          byp1_hit,
    output logic                          byp2_hit,
    output logic [XLEN-1:0]               byp1_data,
    output logic [XLEN-1:0]               byp2_data,
    output logic [$clog2(BUF_DEPTH):0]    fifo_count
);

    import wb_pkg::*;

    localparam int                    c_STARVE_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    localparam logic [0:0] c_ST_MEM_PRI   = 1'b0;
    localparam logic [0:0] c_ST_ALU_FORCE = 1'b1;

    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [0:0]            w_state;
    wb_req_t               w_alu_req;
    wb_req_t               w_head;
    wb_req_t               w_win_req;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_alu_push;
    logic                  w_alu_pop;
    logic                  w_mem_win;
    logic                  w_win_valid;

    // Arbitration mode is a pure decode of the starvation counter.
    assign w_state = (r_starve_cnt == c_STARVE_MAX) ? c_ST_ALU_FORCE : c_ST_MEM_PRI;

    assign alu_ready  = !w_full;
    assign w_alu_push = alu_valid && !w_full && !reset;
    assign w_alu_req  = '{rd: alu_rd, data: alu_data};

    assign w_mem_win = mem_valid && (w_state == c_ST_MEM_PRI) && !reset;
    assign mem_ready = w_mem_win;
    // Empty is registered, so a same-cycle push is never popped straight through.
    assign w_alu_pop = !w_mem_win && !w_empty && !reset;

    assign w_win_valid = w_mem_win || w_alu_pop;
    assign w_win_req   = w_mem_win ? wb_req_t'{rd: mem_rd, data: mem_data} : w_head;

    wb_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_alu_push),
        .i_din   (w_alu_req),
        .i_pop   (w_alu_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset || w_empty || w_alu_pop) begin
            r_starve_cnt <= '0;
        end else if (w_mem_win) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // x0 results are still consumed upstream but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (w_win_valid && !is_x0(w_win_req.rd)) begin
            rf_we    <= 1'b1;
            rf_rd    <= w_win_req.rd;
            rf_wdata <= w_win_req.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // Covers the posedge-to-negedge window before the register file updates.
    assign byp1_hit  = rf_we && (rf_rd == rs1) && (rs1 != '0);
    assign byp2_hit  = rf_we && (rf_rd == rs2) && (rs2 != '0);
    assign byp1_data = rf_wdata;
    assign byp2_data = rf_wdata;
`else
    logic w_unused_rs;
    assign w_unused_rs = ^{rs1, rs2};
    assign byp1_hit    = 1'b0;
    assign byp2_hit    = 1'b0;
    assign byp1_data   = '0;
    assign byp2_data   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_writeback_arbiter
// Purpose  : Self-checking bench: vector table plus write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_writeback_arbiter;

    localparam int c_DEPTH  = 2;
    localparam int c_STARVE = 3;
`ifdef WB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    typedef struct {
        logic        mv;
        logic [4:0]  mrd;
        logic [63:0] mdata;
        logic        av;
        logic [4:0]  ard;
        logic [63:0] adata;
        logic        e_mr;
        logic        e_ar;
        logic [1:0]  e_cnt;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, rf_rd, rs1, rs2;
    logic [63:0] alu_data, mem_data, rf_wdata, byp1_data, byp2_data;
    logic        rf_we, byp1_hit, byp2_hit;
    logic [1:0]  fifo_count;

    int   nchk = 0;
    int   nerr = 0;
    wb_t  exp_q[$];
    wb_t  m_q[$];
    int   m_starve = 0;
    logic mon_en = 1'b1;
    wb_t  mon_e;

    logic        byp_chk = 1'b0;
    logic        e_h1, e_h2;
    logic [63:0] e_d1, e_d2;

    vec_t vecs [22];

    wb_writeback_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .rs1        (rs1),
        .rs2        (rs2),
        .byp1_hit   (byp1_hit),
        .byp2_hit   (byp2_hit),
        .byp1_data  (byp1_data),
        .byp2_data  (byp2_data),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write port monitor: exactly the queued write, or none.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("rf_we", {63'd0, rf_we}, 64'd1);
                chk("rf_rd", {59'd0, rf_rd}, {59'd0, mon_e.rd});
                chk("rf_wdata", rf_wdata, mon_e.data);
            end else begin
                chk("rf_we_idle", {63'd0, rf_we}, 64'd0);
            end
        end
    end

    // One cycle of stimulus; a reference model predicts handshakes and writes.
    task automatic drive_cycle(input logic mv_i, input logic [4:0] mrd_i, input logic [63:0] mdata_i,
                               input logic av_i, input logic [4:0] ard_i, input logic [63:0] adata_i,
                               output logic s_mr, output logic s_ar, output logic [1:0] s_cnt);
        int   n;
        logic e_force, e_mwin, e_pop;
        wb_t  h;
        @(negedge clk);
        reset     = 1'b0;
        mem_valid = mv_i;  mem_rd = mrd_i;  mem_data = mdata_i;
        alu_valid = av_i;  alu_rd = ard_i;  alu_data = adata_i;
        #1;
        n       = m_q.size();
        e_force = (m_starve == c_STARVE);
        e_mwin  = mv_i && !e_force;
        e_pop   = !e_mwin && (n > 0);
        s_mr = mem_ready;  s_ar = alu_ready;  s_cnt = fifo_count;
        chk("model_mem_ready", {63'd0, mem_ready}, {63'd0, e_mwin});
        chk("model_alu_ready", {63'd0, alu_ready}, {63'd0, (n < c_DEPTH)});
        chk("model_fifo_count", {62'd0, fifo_count}, 64'(n));
        if (byp_chk) begin
            chk("byp1_hit", {63'd0, byp1_hit}, {63'd0, e_h1});
            chk("byp1_data", byp1_data, e_d1);
            chk("byp2_hit", {63'd0, byp2_hit}, {63'd0, e_h2});
            chk("byp2_data", byp2_data, e_d2);
        end
        if (e_mwin && mrd_i != 5'd0) exp_q.push_back(wb_t'{mrd_i, mdata_i});
        if (e_pop) begin
            h = m_q.pop_front();
            if (h.rd != 5'd0) exp_q.push_back(h);
        end
        if (n == 0 || e_pop) m_starve = 0;
        else if (e_mwin)     m_starve++;
        if (av_i && n < c_DEPTH) m_q.push_back(wb_t'{ard_i, adata_i});
        @(posedge clk);
    endtask

    task automatic reset_cycles(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset = 1'b1;
            mem_valid = 1'b1;  mem_rd = 5'd6;  mem_data = 64'hBAD;
            alu_valid = 1'b1;  alu_rd = 5'd6;  alu_data = 64'hBAD;
            #1;
            chk("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
            if (i > 0) begin
                chk("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
                chk("rst_fifo_count", {62'd0, fifo_count}, 64'd0);
                chk("rst_rf_rd", {59'd0, rf_rd}, 64'd0);
                chk("rst_rf_wdata", rf_wdata, 64'd0);
                chk("rst_byp_hit", {62'd0, byp1_hit, byp2_hit}, 64'd0);
                chk("rst_byp_data", byp1_data | byp2_data, 64'd0);
            end
            m_q.delete();
            m_starve = 0;
            @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       s_mr, s_ar;
        logic [1:0] s_cnt;

        reset = 1'b1;  rs1 = 5'd0;  rs2 = 5'd0;
        mem_valid = 1'b1;  mem_rd = 5'd0;  mem_data = '0;
        alu_valid = 1'b1;  alu_rd = 5'd0;  alu_data = '0;

        //             mv rd     data          av rd     data          mr ar cnt
        vecs[0]  = '{1'b1, 5'd5,  64'hDEAD, 1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'd0};
        vecs[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'd0};
        vecs[2]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd0,  64'h1234, 1'b0, 1'b1, 2'd0};
        vecs[3]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'd1};
        vecs[4]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'd0};
        vecs[5]  = '{1'b1, 5'd3,  64'h30,   1'b1, 5'd7,  64'h77,   1'b1, 1'b1, 2'd0};
        vecs[6]  = '{1'b1, 5'd4,  64'h40,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'd1};
        vecs[7]  = '{1'b1, 5'd5,  64'h50,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'd1};
        vecs[8]  = '{1'b1, 5'd6,  64'h60,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'd1};
        vecs[9]  = '{1'b1, 5'd8,  64'h80,   1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'd1};
        vecs[10] = '{1'b1, 5'd8,  64'h80,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'd0};
        vecs[11] = '{1'b1, 5'd9,  64'h90,   1'b1, 5'd10, 64'hA0,   1'b1, 1'b1, 2'd0};
        vecs[12] = '{1'b1, 5'd9,  64'h91,   1'b1, 5'd11, 64'hB0,   1'b1, 1'b1, 2'd1};
        vecs[13] = '{1'b1, 5'd9,  64'h92,   1'b1, 5'd12, 64'hC0,   1'b1, 1'b0, 2'd2};
        vecs[14] = '{1'b1, 5'd9,  64'h93,   1'b1, 5'd12, 64'hC0,   1'b1, 1'b0, 2'd2};
        vecs[15] = '{1'b1, 5'd9,  64'h94,   1'b1, 5'd12, 64'hC0,   1'b0, 1'b0, 2'd2};
        vecs[16] = '{1'b1, 5'd9,  64'h94,   1'b1, 5'd12, 64'hC0,   1'b1, 1'b1, 2'd1};
        vecs[17] = '{1'b1, 5'd13, 64'hD0,   1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 2'd2};
        vecs[18] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b0, 2'd2};
        vecs[19] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'd1};
        vecs[20] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b1, 2'd0};
        vecs[21] = '{1'b1, 5'd0,  64'hFF,   1'b0, 5'd0,  64'h0,    1'b1, 1'b1, 2'd0};

        reset_cycles(2);

        for (int i = 0; i < 22; i++) begin
            drive_cycle(vecs[i].mv, vecs[i].mrd, vecs[i].mdata,
                        vecs[i].av, vecs[i].ard, vecs[i].adata, s_mr, s_ar, s_cnt);
            chk($sformatf("vec%0d_mem_ready", i), {63'd0, s_mr}, {63'd0, vecs[i].e_mr});
            chk($sformatf("vec%0d_alu_ready", i), {63'd0, s_ar}, {63'd0, vecs[i].e_ar});
            chk($sformatf("vec%0d_fifo_count", i), {62'd0, s_cnt}, {62'd0, vecs[i].e_cnt});
        end

        // Bypass: pending write to x9 compared against rs1/rs2.
        drive_cycle(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'h0, s_mr, s_ar, s_cnt);
        rs1 = 5'd9;  rs2 = 5'd0;
        e_h1 = c_BYP;  e_d1 = c_BYP ? 64'h99 : 64'h0;
        e_h2 = 1'b0;   e_d2 = c_BYP ? 64'h99 : 64'h0;
        byp_chk = 1'b1;
        drive_cycle(1'b1, 5'd9, 64'h55, 1'b0, 5'd0, 64'h0, s_mr, s_ar, s_cnt);
        rs1 = 5'd3;  rs2 = 5'd9;
        e_h1 = 1'b0;   e_d1 = c_BYP ? 64'h55 : 64'h0;
        e_h2 = c_BYP;  e_d2 = c_BYP ? 64'h55 : 64'h0;
        drive_cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, s_mr, s_ar, s_cnt);
        rs1 = 5'd9;  rs2 = 5'd9;
        e_h1 = 1'b0;  e_h2 = 1'b0;
        drive_cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, s_mr, s_ar, s_cnt);
        byp_chk = 1'b0;
        rs1 = 5'd0;  rs2 = 5'd0;

        // Reset mid-operation discards the buffered ALU result.
        drive_cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd14, 64'hE0, s_mr, s_ar, s_cnt);
        drive_cycle(1'b0, 5'd0, 64'h0, 1'b1, 5'd15, 64'hF0, s_mr, s_ar, s_cnt);
        chk("pre_reset_count", {62'd0, s_cnt}, 64'd1);
        reset_cycles(2);
        drive_cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, s_mr, s_ar, s_cnt);
        chk("post_reset_count", {62'd0, s_cnt}, 64'd0);
        drive_cycle(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, s_mr, s_ar, s_cnt);

        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
